// File: rtl/bcd_conv_arb.sv
// bcd_conv_arb: round-robin scheduler that shares one bin_bcd converter between the
// hour/minute/second channels. Define BCD_ARB_TIMEOUT_EN to enable the WAIT timeout and sticky err.
module bcd_conv_arb #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [4:0]    hour,
  input  logic [5:0]    minu,
  input  logic [5:0]    seco,
  input  logic          hour_vld,
  input  logic          minu_vld,
  input  logic          seco_vld,
  output logic [DW-1:0] cvt_bin,
  output logic          cvt_vld,
  input  logic [11:0]   cvt_bcd,
  input  logic          cvt_done,
  output logic [7:0]    hour_bcd,
  output logic [7:0]    minu_bcd,
  output logic [7:0]    seco_bcd,
  output logic [2:0]    bcd_upd,
  output logic          busy,
  output logic          err
);

  // Converter handshake: cvt_vld is a one-cycle issue strobe qualifying cvt_bin; the converter
  // answers with a one-cycle cvt_done qualifying cvt_bcd. No back-pressure; one op in flight.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      pend_q, pend_d;
  logic [2:0][5:0] hold_q, hold_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      sel_q, sel_d;
  logic [DW-1:0]   cvt_bin_q, cvt_bin_d;
  logic            cvt_vld_q, cvt_vld_d;
  logic [2:0][7:0] bcd_q, bcd_d;
  logic [2:0]      bcd_upd_q, bcd_upd_d;
  logic [1:0]      cand0, cand1, cand2, gnt;

`ifdef BCD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  logic unused_bcd_hi;
  assign unused_bcd_hi = &{1'b0, cvt_bcd[11:8]};

  function automatic logic [1:0] wrap_inc(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // First pending channel scanning from ptr in hour -> minute -> second order.
  always_comb begin
    cand0 = ptr_q;
    cand1 = wrap_inc(cand0);
    cand2 = wrap_inc(cand1);
    if (pend_q[cand0])      gnt = cand0;
    else if (pend_q[cand1]) gnt = cand1;
    else                    gnt = cand2;
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    hold_d    = hold_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    cvt_bin_d = cvt_bin_q;
    cvt_vld_d = 1'b0;
    bcd_d     = bcd_q;
    bcd_upd_d = 3'b000;
`ifdef BCD_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (|pend_q) begin
          sel_d       = gnt;
          cvt_bin_d   = DW'(hold_q[gnt]);
          cvt_vld_d   = 1'b1;
          pend_d[gnt] = 1'b0;
          state_d     = S_WAIT;
`ifdef BCD_ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      S_WAIT: begin
        if (cvt_done) begin
          bcd_d[sel_q]     = cvt_bcd[7:0];
          bcd_upd_d[sel_q] = 1'b1;
          ptr_d            = wrap_inc(sel_q);
          state_d          = S_IDLE;
        end
`ifdef BCD_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          ptr_d   = wrap_inc(sel_q);
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Capture last so a strobe coinciding with its own grant re-arms pend with the new value.
    if (hour_vld) begin
      pend_d[0] = 1'b1;
      hold_d[0] = {1'b0, hour};
    end
    if (minu_vld) begin
      pend_d[1] = 1'b1;
      hold_d[1] = minu;
    end
    if (seco_vld) begin
      pend_d[2] = 1'b1;
      hold_d[2] = seco;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pend_q    <= '0;
      hold_q    <= '0;
      ptr_q     <= 2'd0;
      sel_q     <= 2'd0;
      cvt_bin_q <= '0;
      cvt_vld_q <= 1'b0;
      bcd_q     <= '0;
      bcd_upd_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      hold_q    <= hold_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      cvt_bin_q <= cvt_bin_d;
      cvt_vld_q <= cvt_vld_d;
      bcd_q     <= bcd_d;
      bcd_upd_q <= bcd_upd_d;
    end
  end

`ifdef BCD_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // busy doubles as the FSM state observation point (WAIT = 1).
  assign busy     = (state_q == S_WAIT);
  assign cvt_bin  = cvt_bin_q;
  assign cvt_vld  = cvt_vld_q;
  assign hour_bcd = bcd_q[0];
  assign minu_bcd = bcd_q[1];
  assign seco_bcd = bcd_q[2];
  assign bcd_upd  = bcd_upd_q;

endmodule

// File: tb/tb_bcd_conv_arb.sv
// Testbench for bcd_conv_arb: randomized strobes and converter latency checked against a
// channel-level reference model; bench acts as the shared converter.
module tb_bcd_conv_arb;
  localparam int DW      = 8;
  localparam int TIMEOUT = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]    hour = '0;
  logic [5:0]    minu = '0, seco = '0;
  logic          hour_vld = 1'b0, minu_vld = 1'b0, seco_vld = 1'b0;
  logic [DW-1:0] cvt_bin;
  logic          cvt_vld;
  logic [11:0]   cvt_bcd = '0;
  logic          cvt_done = 1'b0;
  logic [7:0]    hour_bcd, minu_bcd, seco_bcd;
  logic [2:0]    bcd_upd;
  logic          busy, err;

  bcd_conv_arb #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .hour(hour), .minu(minu), .seco(seco),
    .hour_vld(hour_vld), .minu_vld(minu_vld), .seco_vld(seco_vld),
    .cvt_bin(cvt_bin), .cvt_vld(cvt_vld), .cvt_bcd(cvt_bcd), .cvt_done(cvt_done),
    .hour_bcd(hour_bcd), .minu_bcd(minu_bcd), .seco_bcd(seco_bcd),
    .bcd_upd(bcd_upd), .busy(busy), .err(err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model state (channel 0 = hour, 1 = minute, 2 = second)
  bit        m_pend[3];
  int        m_hold[3];
  int        m_bcd[3];
  int        m_ptr, m_sel, m_cur, m_wait, m_bin;
  bit        m_busy, m_err;
  logic [7:0] exp_q[$];
  int        dut_issue[$];
  logic [2:0] upd_seen;

  // converter model
  bit conv_busy, conv_mute, stray_done;
  int conv_lat, conv_bin, lat_lo = 0, lat_hi = 4;

  function automatic int to_bcd(input int v);
    return ((v / 10) << 4) | (v % 10);
  endfunction

  function automatic logic [7:0] dut_ch(input int c);
    return (c == 0) ? hour_bcd : (c == 1) ? minu_bcd : seco_bcd;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_pend[c] = 0; m_hold[c] = 0; m_bcd[c] = 0;
    end
    m_ptr = 0; m_sel = 0; m_cur = 0; m_wait = 0; m_bin = 0;
    m_busy = 0; m_err = 0;
    conv_busy = 0;
    exp_q.delete();
  endtask

  // one clock: converter drive, edge, model update, output comparison
  task automatic step();
    bit [2:0] v;
    int val[3];
    int e_upd, done_ch;
    bit e_vld;
    cvt_done = 1'b0;
    cvt_bcd  = 12'($urandom);
    if (conv_busy && !conv_mute) begin
      if (conv_lat == 0) begin
        cvt_done  = 1'b1;
        cvt_bcd   = {4'($urandom), 8'(to_bcd(conv_bin))};
        conv_busy = 0;
      end else conv_lat--;
    end else if (!conv_busy && stray_done) cvt_done = 1'b1;
    v = {seco_vld, minu_vld, hour_vld};
    val[0] = int'(hour); val[1] = int'(minu); val[2] = int'(seco);

    @(posedge clk);
    e_vld = 0; e_upd = 0; done_ch = 0;
    if (!m_busy) begin
      for (int k = 0; k < 3; k++) begin
        int c;
        c = (m_ptr + k) % 3;
        if (m_pend[c]) begin
          e_vld = 1; m_bin = m_hold[c]; m_cur = m_hold[c];
          m_pend[c] = 0; m_sel = c; m_busy = 1; m_wait = 0;
          exp_q.push_back(8'(to_bcd(m_cur)));
          break;
        end
      end
    end else begin
      m_wait++;
      if (cvt_done) begin
        m_bcd[m_sel] = to_bcd(m_cur);
        e_upd = 1 << m_sel; done_ch = m_sel;
        m_ptr = (m_sel + 1) % 3; m_busy = 0;
      end
`ifdef BCD_ARB_TIMEOUT_EN
      else if (m_wait == TIMEOUT) begin
        m_err = 1; m_ptr = (m_sel + 1) % 3; m_busy = 0;
        conv_busy = 0;
        void'(exp_q.pop_front());
      end
`endif
    end
    for (int c = 0; c < 3; c++)
      if (v[c]) begin m_pend[c] = 1; m_hold[c] = val[c]; end

    #1;
    check("cvt_vld", cvt_vld, e_vld);
    check("cvt_bin", cvt_bin, m_bin);
    check("bcd_upd", bcd_upd, e_upd);
    check("hour_bcd", hour_bcd, m_bcd[0]);
    check("minu_bcd", minu_bcd, m_bcd[1]);
    check("seco_bcd", seco_bcd, m_bcd[2]);
    check("busy", busy, m_busy);
    check("err", err, m_err);
    upd_seen |= bcd_upd;
    if (cvt_vld) dut_issue.push_back(int'(cvt_bin));
    if (e_upd != 0) begin
      check("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("sb_bcd", dut_ch(done_ch), exp_q.pop_front());
    end
    if (e_vld) begin
      conv_busy = 1; conv_bin = m_cur;
      conv_lat = $urandom_range(lat_hi, lat_lo);
    end
    hour_vld = 1'b0; minu_vld = 1'b0; seco_vld = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_busy || conv_busy || m_pend[0] || m_pend[1] || m_pend[2]) && n < 300) begin
      step();
      n++;
    end
    check("drain_bound", n < 300, 1);
  endtask

  task automatic do_reset();
    hour_vld = 1'b0; minu_vld = 1'b0; seco_vld = 1'b0;
    cvt_done = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_hour_bcd", hour_bcd, 0);
    check("rst_minu_bcd", minu_bcd, 0);
    check("rst_seco_bcd", seco_bcd, 0);
    check("rst_upd", bcd_upd, 0);
    check("rst_cvt_vld", cvt_vld, 0);
    check("rst_cvt_bin", cvt_bin, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    dut_issue.delete();
    upd_seen = '0;
  endtask

  initial begin
    #3;
    do_reset();

    // single minute conversion
    minu = 6'd45; minu_vld = 1'b1;
    step();
    drain();
    check("t1_minu_bcd", minu_bcd, 8'h45);
    check("t1_upd", upd_seen, 3'b010);
    check("t1_issues", dut_issue.size(), 1);
    if (dut_issue.size() == 1) check("t1_bin", dut_issue[0], 45);

    // all three strobes in one cycle, then a second burst
    do_reset();
    hour = 5'd23; minu = 6'd59; seco = 6'd7;
    hour_vld = 1'b1; minu_vld = 1'b1; seco_vld = 1'b1;
    step();
    drain();
    check("t2_issues", dut_issue.size(), 3);
    if (dut_issue.size() == 3) begin
      check("t2_order0", dut_issue[0], 23);
      check("t2_order1", dut_issue[1], 59);
      check("t2_order2", dut_issue[2], 7);
    end
    check("t2_hour", hour_bcd, 8'h23);
    check("t2_minu", minu_bcd, 8'h59);
    check("t2_seco", seco_bcd, 8'h07);
    dut_issue.delete();
    hour = 5'd1; minu = 6'd2; seco = 6'd3;
    hour_vld = 1'b1; minu_vld = 1'b1; seco_vld = 1'b1;
    step();
    drain();
    check("t2b_first_hour", dut_issue.size() > 0 ? dut_issue[0] : -1, 1);

    // two second strobes while hour is in flight: only the latest is converted
    do_reset();
    lat_lo = 10; lat_hi = 10;
    hour = 5'd5; hour_vld = 1'b1;
    step();
    step();
    seco = 6'd10; seco_vld = 1'b1;
    step();
    step();
    seco = 6'd11; seco_vld = 1'b1;
    step();
    drain();
    check("t3_issues", dut_issue.size(), 2);
    if (dut_issue.size() == 2) check("t3_seco_bin", dut_issue[1], 11);
    check("t3_seco_bcd", seco_bcd, 8'h11);
    lat_lo = 0; lat_hi = 4;

    // reset while waiting, then a late cvt_done in IDLE
    do_reset();
    lat_lo = 8; lat_hi = 8;
    hour = 5'd12; hour_vld = 1'b1;
    step();
    step();
    step();
    check("t4_busy_before", busy, 1);
    do_reset();
    stray_done = 1;
    step();
    step();
    stray_done = 0;
    check("t4_hour_after", hour_bcd, 0);
    check("t4_upd_after", upd_seen, 0);
    lat_lo = 0; lat_hi = 4;

`ifdef BCD_ARB_TIMEOUT_EN
    // converter never answers: abandon after TIMEOUT cycles, then serve the next channel
    begin
      int n;
      do_reset();
      conv_mute = 1;
      hour = 5'd9; minu = 6'd30; hour_vld = 1'b1; minu_vld = 1'b1;
      step();
      step();
      n = 0;
      while (m_busy && n < 200) begin
        step();
        n++;
      end
      check("t5_tmo_len", n, TIMEOUT);
      check("t5_err", err, 1);
      check("t5_hour_kept", hour_bcd, 0);
      conv_mute = 0;
      drain();
      check("t5_next_bin", dut_issue.size() > 1 ? dut_issue[1] : -1, 30);
      check("t5_minu", minu_bcd, 8'h30);
      check("t5_no_hour_upd", upd_seen[0], 0);
    end
`endif

    // randomized traffic
    do_reset();
    for (int i = 0; i < 500; i++) begin
      hour_vld = ($urandom_range(3, 0) == 0);
      minu_vld = ($urandom_range(3, 0) == 0);
      seco_vld = ($urandom_range(3, 0) == 0);
      hour = 5'($urandom_range(23, 0));
      minu = 6'($urandom_range(59, 0));
      seco = 6'($urandom_range(59, 0));
      stray_done = ($urandom_range(7, 0) == 0);
      step();
    end
    stray_done = 0;
    drain();
    check("sb_leftover", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
